muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the execute stage, beside the ALU.
//  Takes the same register-file operands (a = rs, b = rt) and produces the HI/LO pair.
//  Serves MULT, MULTU, DIV and DIVU; MFHI/MFLO read HI/LO; MTHI/MTLO write them.
//  The control unit stalls the pipeline while busy = 1.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high reset
//  start         in   1      launch op; sampled only in IDLE
//  op            in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a             in   WIDTH  rs: multiplicand / dividend
//  b             in   WIDTH  rt: multiplier / divisor
//  hi_we         in   1      MTHI write enable
//  lo_we         in   1      MTLO write enable
//  wdata         in   WIDTH  MTHI/MTLO data
//  busy          out  1      high while an op is in flight
//  done          out  1      one-cycle pulse when HI/LO take a result
//  div_by_zero   out  1      pulses with done when a DIV/DIVU had b == 0
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, any time): state=IDLE; busy=0, done=0, div_by_zero=0; hi=lo=0.
//   An op in flight is discarded.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: start=1 at edge E0 does the following, then goes to RUN:
//    - latches op;
//    - latches |a| and |b| (magnitudes for signed ops; raw values for unsigned);
//    - latches the result signs;
//    - clears the partial result and count.
//   RUN: one step per edge for WIDTH edges (E1..E32); then goes to FIX.
//    - Multiply: shift-add, 2*WIDTH-bit product.
//    - Divide: restoring, one quotient bit per edge.
//   FIX (edge E33): applies the sign fixup, writes hi/lo, goes to IDLE.
//  Timing:
//   - busy=1 in RUN and FIX (cycles after E0 through E33); busy is registered.
//   - done=1 for exactly one cycle after E33; the new hi/lo are visible in that cycle.
//   - Latency from start edge to result = WIDTH+1 edges.
//  start while busy: ignored, no queueing.
//  start in the done cycle: accepted (state is IDLE).
//  Multiply results:
//   - {hi,lo} = full 64-bit product.
//   - MULT: signed; the product is negated when sign(a) ^ sign(b).
//   - MULTU: unsigned.
//  Divide results:
//   - lo = quotient, truncated toward zero; quotient sign = sign(a) ^ sign(b).
//   - hi = remainder; remainder sign = sign(a).
//   - DIV 0x8000_0000 / -1 -> lo = 0x8000_0000, hi = 0. No trap, no flag.
//  Divide by zero (b == 0, DIV or DIVU):
//   - Full latency still applies.
//   - hi = a (original value); lo = 32'hFFFF_FFFF.
//   - div_by_zero pulses together with done.
//  MTHI/MTLO: hi_we/lo_we write wdata at the clock edge, only in IDLE.
//   - Ignored while busy.
//   - hi_we and lo_we may both be set in the same cycle.
//   - Write in the same IDLE cycle as start: the write lands; the op result later overwrites it.
//  a, b and op may change after the start edge; the unit uses only the latched copies.
// TESTING
//  1 MULTU a=FFFFFFFF b=FFFFFFFF -> done 33 edges after start; hi=FFFFFFFE, lo=00000001.
//  2 MULT a=-3 b=7 -> hi=FFFFFFFF, lo=FFFFFFEB.
//    DIVU a=100 b=7 -> lo=0000000E, hi=00000002.
//  3 DIV a=-7 b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//    DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
//  4 DIVU a=5 b=0 -> hi=5, lo=FFFFFFFF; div_by_zero=1 for one cycle with done.
//  5 Second start at cycle 10 of a MULT -> ignored; exactly one done pulse.
//    hi_we during busy -> hi unchanged.
//    MTLO 1234 in IDLE -> lo=1234 next cycle.
//  6 reset asserted mid-RUN (no clock edge) -> busy=0 and hi=lo=0 immediately.
//    After deassert, a new MULT 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the HI/LO pair.
// Shift-add multiply and restoring divide on magnitudes, sign fixup in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;

  logic               sgn;
  logic [WIDTH:0]     msum, trial, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;

  function automatic logic [WIDTH-1:0] fix_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_2w(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    sgn      = ~op[0];

    // Multiply: low half holds the unconsumed multiplier, high half the running sum.
    msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? ma_q : '0)};
    mul_next = {msum, acc_q[WIDTH-1:1]};
    // Divide: high half is the remainder, low half shifts dividend out and quotient in.
    trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = trial - {1'b0, mb_q};
    div_next = {(diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0]),
                acc_q[WIDTH-2:0], ~diff[WIDTH]};
    prod     = fix_2w(qneg_q, acc_q);

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = op[1];
          ma_d     = fix_w(sgn & a[WIDTH-1], a);
          mb_d     = fix_w(sgn & b[WIDTH-1], b);
          qneg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = sgn & a[WIDTH-1];
          bz_d     = (b == '0);
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? ma_d : mb_d)};
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = fix_w(rneg_q, acc_q[2*WIDTH-1:WIDTH]);
          lo_d = bz_q ? '1 : fix_w(qneg_q, acc_q[WIDTH-1:0]);
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        dbz_d   = is_div_q & bz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/datapath registers are qualified by the FSM and need no reset.
  always_ff @(posedge clk) begin
    ma_q     <= ma_d;
    mb_q     <= mb_d;
    acc_q    <= acc_d;
    is_div_q <= is_div_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
    bz_q     <= bz_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
